// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: serial receive front end of the system UART.
// Oversamples the asynchronous rx pin, deframes 8N1 characters (LSB first) and
// queues received bytes in a small show-ahead FIFO drained by a valid/ready handshake.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   rx         asynchronous serial line, idles high
//   rx_data    byte at the FIFO head (meaningful while rx_valid=1)
//   rx_valid   FIFO not empty
//   rx_ready   consumer pops the head when rx_valid && rx_ready
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: completed byte dropped, FIFO full
//   busy       deframer is not idle
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 64,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   LVL_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   LVL_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; both stages reset to the idle (high) level.
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Deframer
    // ------------------------------------------------------------------
    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitidx;
    logic [7:0]       shreg;

    logic stop_sample;
    logic push;

    assign stop_sample = (state == StStop) && (cnt == BIT_LAST);
    // The push happens on the same edge the stop bit is sampled.
    assign push        = stop_sample && rx_s;
    assign busy        = (state != StIdle);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            cnt       <= '0;
            bitidx    <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                StIdle: begin
                    if (!rx_s) begin
                        state <= StStart;
                        cnt   <= '0;
                    end
                end
                StStart: begin
                    if (cnt == HALF_LAST) begin
                        cnt    <= '0;
                        bitidx <= '0;
                        // A start bit that is gone by mid-bit is treated as a glitch.
                        state  <= rx_s ? StIdle : StData;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                StData: begin
                    if (cnt == BIT_LAST) begin
                        cnt    <= '0;
                        shreg  <= {rx_s, shreg[7:1]};
                        bitidx <= bitidx + 3'd1;
                        if (bitidx == 3'd7) begin
                            state <= StStop;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                StStop: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= StIdle;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= StBreak;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                StBreak: begin
                    // Hold off until the line returns high so a stuck-low line
                    // cannot generate a stream of bogus frames.
                    if (rx_s) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic full;
    logic pop;
    logic wr_en;

    assign rx_valid = (count != '0);
    assign rx_data  = mem[rd_ptr];
    assign full     = (count == LVL_FULL);
    assign pop      = rx_valid && rx_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign wr_en    = push && (!full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (wr_en) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + LVL_ONE;
                2'b01:   count <= count - LVL_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed, table-driven bench for uart_rx_fifo.
// Frames are driven one bit every CPB clocks, aligned to the falling clock edge;
// outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CPB       = 64;
    localparam int FRAME_CYC = 10 * CPB;
    localparam int SEND_CYC  = FRAME_CYC + 24;
    // Start bit driven low -> START entry after 3 edges; push 608 edges later.
    localparam int EXP_RISE  = 611;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int fe_total = 0;
    int ov_total = 0;

    always #31.25 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    // Pulse counters: a stretched pulse counts more than once.
    always @(negedge clk) begin
        if (frame_err) fe_total <= fe_total + 1;
        if (overrun)   ov_total <= ov_total + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one 8N1 frame then idle. pop_at raises rx_ready for the cycle after that
    // iteration; reset_at asserts reset mid-frame and aborts. rise = edges from the
    // start bit until rx_valid was first seen rising (-1 if never).
    task automatic send(input logic [7:0] b, input logic stop_bit, input int pop_at,
                        input int reset_at, output int rise);
        logic [9:0] frame;
        logic       prev_valid;
        frame      = {stop_bit, b, 1'b0};
        rise       = -1;
        prev_valid = rx_valid;
        for (int k = 0; k < SEND_CYC; k++) begin
            rx       = (k < FRAME_CYC) ? frame[k / CPB] : 1'b1;
            rx_ready = (k == pop_at);
            if (k == reset_at) begin
                #5;
                reset = 1'b0;
                #1;
                chk("rst_mid_valid", {31'd0, rx_valid}, 0);
                chk("rst_mid_data", {24'd0, rx_data}, 0);
                chk("rst_mid_busy", {31'd0, busy}, 0);
                chk("rst_mid_ferr", {31'd0, frame_err}, 0);
                chk("rst_mid_ovr", {31'd0, overrun}, 0);
                rx       = 1'b1;
                rx_ready = 1'b0;
                return;
            end
            @(negedge clk);
            if (rise < 0 && !prev_valid && rx_valid) rise = k + 1;
            prev_valid = rx_valid;
        end
        rx_ready = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        chk({name, "_valid"}, {31'd0, rx_valid}, 1);
        chk({name, "_data"}, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int rise;
        int fe0;
        int ov0;
        logic busy_mid;
        logic busy_late;

        vecs[0] = '{8'h31, 1'b1, 1'b1, 8'h31, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
        vecs[4] = '{8'h55, 1'b0, 1'b0, 8'h00, 1};
        vecs[5] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        vecs[6] = '{8'h6B, 1'b1, 1'b1, 8'h6B, 0};

        // Reset state
        #100;
        chk("reset_valid", {31'd0, rx_valid}, 0);
        chk("reset_data", {24'd0, rx_data}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_ferr", {31'd0, frame_err}, 0);
        chk("reset_ovr", {31'd0, overrun}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Single-frame table
        foreach (vecs[i]) begin
            fe0 = fe_total;
            ov0 = ov_total;
            send(vecs[i].data, vecs[i].stop_bit, -1, -1, rise);
            chk("vec_valid", {31'd0, rx_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk("vec_latency_in_window",
                    {31'd0, (rise >= EXP_RISE - CPB) && (rise <= EXP_RISE + CPB)}, 1);
                pop_check("vec_pop", vecs[i].exp_data);
                chk("vec_empty_after_pop", {31'd0, rx_valid}, 0);
            end
            chk("vec_ferr_pulses", fe_total - fe0, vecs[i].exp_fe);
            chk("vec_ovr_pulses", ov_total - ov0, 0);
            chk("vec_busy_idle", {31'd0, busy}, 0);
        end

        // Back-to-back frames
        fe0 = fe_total;
        ov0 = ov_total;
        send(8'h31, 1'b1, -1, -1, rise);
        send(8'h32, 1'b1, -1, -1, rise);
        pop_check("b2b_first", 8'h31);
        pop_check("b2b_second", 8'h32);
        chk("b2b_empty", {31'd0, rx_valid}, 0);
        chk("b2b_ferr", fe_total - fe0, 0);
        chk("b2b_ovr", ov_total - ov0, 0);

        // Start-bit glitch: 16 cycles low
        fe0 = fe_total;
        ov0 = ov_total;
        busy_mid  = 1'b0;
        busy_late = 1'b1;
        for (int k = 0; k < 60; k++) begin
            rx = (k < 16) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (k + 1 == 20) busy_mid = busy;
            if (k + 1 == 36) busy_late = busy;
        end
        chk("glitch_busy_in_start", {31'd0, busy_mid}, 1);
        chk("glitch_busy_cleared", {31'd0, busy_late}, 0);
        chk("glitch_no_push", {31'd0, rx_valid}, 0);
        chk("glitch_ferr", fe_total - fe0, 0);
        chk("glitch_ovr", ov_total - ov0, 0);

        // Overrun: five frames into a depth-4 FIFO
        ov0 = ov_total;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, -1, -1, rise);
        chk("ovr_pulses", ov_total - ov0, 1);
        for (int i = 1; i <= 4; i++) pop_check("ovr_pop", 8'(i));
        chk("ovr_empty", {31'd0, rx_valid}, 0);

        // Full FIFO with a pop on the fifth push edge
        ov0 = ov_total;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, -1, -1, rise);
        chk("fullpop_head", {24'd0, rx_data}, 8'h01);
        send(8'h05, 1'b1, EXP_RISE - 1, -1, rise);
        chk("fullpop_no_ovr", ov_total - ov0, 0);
        for (int i = 2; i <= 5; i++) pop_check("fullpop_pop", 8'(i));
        chk("fullpop_empty", {31'd0, rx_valid}, 0);

        // Reset mid-frame with two bytes queued
        send(8'hAA, 1'b1, -1, -1, rise);
        send(8'hBB, 1'b1, -1, -1, rise);
        chk("rst_queued", {31'd0, rx_valid}, 1);
        send(8'h31, 1'b1, -1, 300, rise);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_after_valid", {31'd0, rx_valid}, 0);
        send(8'h32, 1'b1, -1, -1, rise);
        pop_check("rst_sole", 8'h32);
        chk("rst_sole_empty", {31'd0, rx_valid}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
